// File: rtl/con_port_checker.sv
// rtl/con_port_checker.sv - self-check sequencer that sweeps data memory through the console port
// Detects program end from a stalled fetch stream, then compares every word against an expected ROM.
module con_port_checker #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LAST_ADDR  = 49,
  parameter int HALT_COUNT = 10,
  parameter int CNT_W      = 32
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              enable,
  input  logic [31:0]       if_inst,
  output logic [3:0]        con_write,
  output logic [DATA_W-1:0] con_in,
  output logic [ADDR_W-1:0] con_addr,
  input  logic [DATA_W-1:0] con_out,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr
);

  typedef enum logic [2:0] {IDLE, RUN, DUMP, DRAIN, DONE} state_t;

  localparam int                 MATCH_W = $clog2(HALT_COUNT + 1);
  localparam logic [ADDR_W-1:0]  LAST    = ADDR_W'(LAST_ADDR);
  localparam logic [MATCH_W-1:0] HALT_M1 = MATCH_W'(HALT_COUNT - 1);

  state_t             state, state_nxt;
  logic [31:0]        last_inst;
  logic [MATCH_W-1:0] match_cnt;
  logic               rd_valid;
  logic [ADDR_W-1:0]  rd_addr;
  logic               inst_same, halt_hit, word_ok, clear_all;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign inst_same = (if_inst == last_inst);
  assign halt_hit  = inst_same && (match_cnt == HALT_M1);
  assign word_ok   = (con_out == exp_data);
  assign clear_all = (state == IDLE) || (((state == RUN) || (state == DONE)) && !enable);

  assign con_write = '0;
  assign con_in    = '0;
  assign exp_addr  = con_addr;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable)       state_nxt = IDLE;
        else if (halt_hit) state_nxt = DUMP;
      end
      DUMP:    if (con_addr == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DUMP, DRAIN: busy = 1'b1;
      DONE:             done = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      con_addr        <= '0;
      mismatch        <= 1'b0;
      cycle_cnt       <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      first_fail_addr <= '1;
      last_inst       <= '0;
      match_cnt       <= '0;
      rd_valid        <= 1'b0;
      rd_addr         <= '0;
    end else begin
      mismatch <= rd_valid && !word_ok;
      // Retire the word whose read data arrived this cycle; fail_cnt==0 marks the first failure.
      if (rd_valid) begin
        if (word_ok) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          fail_cnt <= sat_inc(fail_cnt);
          if (fail_cnt == '0) first_fail_addr <= rd_addr;
        end
      end
      case (state)
        RUN: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (inst_same) begin
            match_cnt <= match_cnt + MATCH_W'(1);
          end else begin
            match_cnt <= '0;
            last_inst <= if_inst;
          end
          if (halt_hit) con_addr <= '0;
        end
        DUMP: begin
          rd_valid <= 1'b1;
          rd_addr  <= con_addr;
          if (con_addr != LAST) con_addr <= con_addr + ADDR_W'(1);
        end
        DRAIN:   rd_valid <= 1'b0;
        default: ;
      endcase
      if (clear_all) begin
        con_addr        <= '0;
        mismatch        <= 1'b0;
        cycle_cnt       <= '0;
        pass_cnt        <= '0;
        fail_cnt        <= '0;
        first_fail_addr <= '1;
        last_inst       <= '0;
        match_cnt       <= '0;
        rd_valid        <= 1'b0;
      end
    end
  end

endmodule
